// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, FSM state type and opcode class helper for alu_muldiv_seq
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_MULT  = 4'b1000;
    localparam logic [3:0] ALU_MULTU = 4'b1001;
    localparam logic [3:0] ALU_DIV   = 4'b1010;
    localparam logic [3:0] ALU_DIVU  = 4'b1011;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_MTHI  = 4'b1101;
    localparam logic [3:0] ALU_MTLO  = 4'b1110;
    localparam logic [3:0] ALU_SLTU  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } state_t;

    // MULT, MULTU, DIV and DIVU share the 10xx code space
    function automatic logic is_iterative(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative shift-add multiplier / restoring divider with sign fix-up
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CNT_W = $clog2(WIDTH);

    // p_hi/p_lo: product halves for multiply, remainder/quotient for divide
    logic [WIDTH-1:0] p_hi, p_lo, opb, a_raw;
    logic [CNT_W-1:0] cnt;
    logic             div_q, neg_p, neg_r, div0;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum, trial;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot, rem;

    always_comb begin
        mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
        mag_b = (is_signed && b[WIDTH-1]) ? -b : b;
        sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opb} : '0);
        trial = {p_hi, p_lo[WIDTH-1]} - {1'b0, opb};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            p_hi  <= '0;
            p_lo  <= '0;
            opb   <= '0;
            a_raw <= '0;
            cnt   <= '0;
            div_q <= 1'b0;
            neg_p <= 1'b0;
            neg_r <= 1'b0;
            div0  <= 1'b0;
        end else if (load) begin
            p_hi  <= '0;
            p_lo  <= mag_a;
            opb   <= mag_b;
            a_raw <= a;
            cnt   <= '0;
            div_q <= is_div;
            neg_p <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= is_signed && a[WIDTH-1];
            div0  <= (b == '0);
        end else if (step) begin
            cnt <= cnt + 1'b1;
            if (div_q) begin
                // trial[WIDTH] set means the shifted remainder was below the divisor
                p_hi <= trial[WIDTH] ? {p_hi[WIDTH-2:0], p_lo[WIDTH-1]} : trial[WIDTH-1:0];
                p_lo <= {p_lo[WIDTH-2:0], ~trial[WIDTH]};
            end else begin
                p_hi <= sum[WIDTH:1];
                p_lo <= {sum[0], p_lo[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        prod     = {p_hi, p_lo};
        prod_fix = neg_p ? -prod : prod;
        quot     = neg_p ? -p_lo : p_lo;
        rem      = neg_r ? -p_hi : p_hi;
        if (!div_q) begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end else if (div0) begin
            res_hi = a_raw;
            res_lo = '1;
        end else begin
            res_hi = rem;
            res_lo = quot;
        end
    end

    assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - registered EX-stage ALU with Start/Busy/Done and iterative mul/div into HI/LO
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    state_t           state, state_n;
    logic             accept, md_load, md_last;
    logic [WIDTH-1:0] sc_res, md_hi, md_lo;

    assign accept  = Start && !Busy && (state == ST_IDLE);
    assign md_load = accept && is_iterative(ALUControl);

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (md_load) state_n = ST_RUN;
            ST_RUN:  if (md_last) state_n = ST_FIX;
            ST_FIX:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        sc_res = '0;
        case (ALUControl)
            ALU_AND:  sc_res = A & B;
            ALU_OR:   sc_res = A | B;
            ALU_XOR:  sc_res = A ^ B;
            ALU_NOR:  sc_res = ~(A | B);
            ALU_ADD:  sc_res = A + B;
            ALU_SUB:  sc_res = A - B;
            ALU_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            ALU_SLTU: sc_res = {{(WIDTH-1){1'b0}}, A < B};
            ALU_SLL:  sc_res = B << A[SHAMT_W-1:0];
            ALU_SRL:  sc_res = B >> A[SHAMT_W-1:0];
            ALU_MTHI: sc_res = A;
            ALU_MTLO: sc_res = A;
            default:  sc_res = '0;
        endcase
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (Clk),
        .reset_n   (Reset_n),
        .load      (md_load),
        .step      (state == ST_RUN),
        .is_div    (ALUControl[1]),
        .is_signed (!ALUControl[0]),
        .a         (A),
        .b         (B),
        .last      (md_last),
        .res_hi    (md_hi),
        .res_lo    (md_lo)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b1;
            Hi        <= '0;
            Lo        <= '0;
        end else begin
            state <= state_n;
            Done  <= 1'b0;
            if (md_load) begin
                Busy <= 1'b1;
            end else if (accept) begin
                ALUResult <= sc_res;
                Zero      <= (sc_res == '0);
                Done      <= 1'b1;
                if (ALUControl == ALU_MTHI) Hi <= A;
                if (ALUControl == ALU_MTLO) Lo <= A;
            end else if (state == ST_FIX) begin
                Hi        <= md_hi;
                Lo        <= md_lo;
                ALUResult <= md_lo;
                Zero      <= (md_lo == '0);
                Done      <= 1'b1;
                Busy      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - randomized self-checking bench for alu_muldiv_seq against an arithmetic reference
module tb_alu_muldiv_seq;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic         Start = 1'b0;
    logic [3:0]   ALUControl = 4'd0;
    logic [W-1:0] A = '0, B = '0;
    logic         Busy, Done, Zero;
    logic [W-1:0] ALUResult, Hi, Lo;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] m_hi = '0, m_lo = '0, m_res = '0;

    always #5 Clk = ~Clk;

    alu_muldiv_seq #(.WIDTH(W)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .ALUControl (ALUControl),
        .A          (A),
        .B          (B),
        .Busy       (Busy),
        .Done       (Done),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Hi         (Hi),
        .Lo         (Lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sp, sq, sr;
        logic [63:0]  up;
        case (op)
            4'b0000: m_res = a & b;
            4'b0001: m_res = a | b;
            4'b0011: m_res = a ^ b;
            4'b1100: m_res = ~(a | b);
            4'b0010: m_res = a + b;
            4'b0110: m_res = a - b;
            4'b0111: m_res = ($signed(a) < $signed(b)) ? 1 : 0;
            4'b1111: m_res = (a < b) ? 1 : 0;
            4'b0100: m_res = b << a[4:0];
            4'b0101: m_res = b >> a[4:0];
            4'b1101: begin m_hi = a; m_res = a; end
            4'b1110: begin m_lo = a; m_res = a; end
            4'b1000: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                m_hi = sp[63:32]; m_lo = sp[31:0]; m_res = m_lo;
            end
            4'b1001: begin
                up = 64'(a) * 64'(b);
                m_hi = up[63:32]; m_lo = up[31:0]; m_res = m_lo;
            end
            4'b1010, 4'b1011: begin
                if (b == 0) begin
                    m_lo = '1; m_hi = a;
                end else if (op == 4'b1010) begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    m_lo = sq[31:0]; m_hi = sr[31:0];
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
                m_res = m_lo;
            end
            default: m_res = '0;
        endcase
    endfunction

    function automatic logic iter_op(input logic [3:0] op);
        return op >= 4'b1000 && op <= 4'b1011;
    endfunction

    // Called just after a falling edge; returns just after the falling edge where Done is seen.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int lat;
        bit busy_ok;
        check({tag, " idle"}, Busy, 1'b0);
        ALUControl = op; A = a; B = b; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        A = $urandom; B = $urandom; ALUControl = 4'($urandom);
        model(op, a, b);
        lat = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge Clk);
            lat++;
            if (!Done && !Busy) busy_ok = 1'b0;
        end while (!Done && lat < 50);
        check({tag, " latency"}, lat, iter_op(op) ? W + 2 : 1);
        if (iter_op(op)) check({tag, " busy held"}, busy_ok, 1'b1);
        check({tag, " busy at done"}, Busy, 1'b0);
        check({tag, " result"}, ALUResult, m_res);
        check({tag, " zero"}, Zero, m_res == 0);
        check({tag, " hi"}, Hi, m_hi);
        check({tag, " lo"}, Lo, m_lo);
    endtask

    initial begin
        logic [3:0] op;
        logic [W-1:0] ra, rb;
        int dones;

        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        check("reset busy", Busy, 1'b0);
        check("reset done", Done, 1'b0);
        check("reset result", ALUResult, 0);
        check("reset zero", Zero, 1'b1);
        check("reset hi", Hi, 0);
        check("reset lo", Lo, 0);

        do_op(4'b0010, 5, 7, "add");
        do_op(4'b0110, 32'h1234, 32'h1234, "sub zero");
        do_op(4'b0111, 32'hFFFF_FFFF, 1, "slt");
        do_op(4'b1111, 32'hFFFF_FFFF, 1, "sltu");
        do_op(4'b0100, 4, 1, "sll");
        do_op(4'b1000, -3, 7, "mult neg");
        do_op(4'b0010, 1, 2, "add in done cycle");
        do_op(4'b1001, 32'hFFFF_FFFF, 2, "multu");
        do_op(4'b1011, 100, 7, "divu");
        do_op(4'b1010, -7, 2, "div neg");
        do_op(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, "div minneg");
        do_op(4'b1011, 9, 0, "divu by zero");
        do_op(4'b1010, -9, 0, "div by zero");
        do_op(4'b1101, 32'hDEAD_BEEF, 0, "mthi");
        do_op(4'b1110, 0, 5, "mtlo zero");

        // Start mid-MULT must be ignored
        ALUControl = 4'b1000; A = 32'd1234; B = -32'd77; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        model(4'b1000, 32'd1234, -32'd77);
        repeat (5) @(negedge Clk);
        ALUControl = 4'b0010; A = 32'd1; B = 32'd1; Start = 1'b1;
        repeat (2) @(negedge Clk);
        Start = 1'b0;
        dones = 0;
        for (int i = 0; i < 40 && dones == 0; i++) begin
            @(negedge Clk);
            if (Done) dones++;
        end
        check("ignored start done", dones, 1);
        check("ignored start result", ALUResult, m_res);
        check("ignored start hi", Hi, m_hi);
        @(negedge Clk);
        check("ignored start no extra done", Done, 1'b0);

        // Reset during RUN aborts the multiply
        ALUControl = 4'b1001; A = 32'h1234_5678; B = 32'h9ABC_DEF0; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (10) @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        m_hi = '0; m_lo = '0; m_res = '0;
        check("abort busy", Busy, 1'b0);
        check("abort done", Done, 1'b0);
        check("abort hi", Hi, 0);
        check("abort lo", Lo, 0);
        check("abort result", ALUResult, 0);
        check("abort zero", Zero, 1'b1);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (Done) dones++;
        end
        check("abort no done", dones, 0);

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb % 32'd50;
            if ($urandom_range(0, 3) == 0 && rb[31]) ra = -ra;
            do_op(op, ra, rb, $sformatf("rand%0d op%0h", i, op));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Parametrised successor to the single-cycle datapath ALU, for the pipelined MIPS core.
- Adds registered outputs and a Start/Busy/Done handshake.
- Adds iterative signed/unsigned multiply and divide writing architectural HI/LO registers, plus XOR, shifts and MTHI/MTLO.
- Sits in the EX stage; the hazard unit stalls the pipeline while Busy=1.

Parameters:
- WIDTH, 32, datapath width of A, B, ALUResult, Hi and Lo. Must be a power of two, at least 8.
- SHAMT_W, $clog2(WIDTH), number of A LSBs used as the shift amount.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset_n  in  1  synchronous, active-low reset, sampled on rising Clk.
- Start  in  1  request: operation is accepted on an edge where Start=1 and Busy=0.
- ALUControl  in  4  operation select, sampled only at acceptance.
- A  in  WIDTH  operand A (shift amount for shifts), sampled at acceptance.
- B  in  WIDTH  operand B, sampled at acceptance.
- Busy  out  1  iterative operation in progress.
- Done  out  1  one-cycle pulse: result outputs updated this cycle.
- ALUResult  out  WIDTH  registered result; for MULT/DIV family it equals the new Lo.
- Zero  out  1  registered, equal to (ALUResult == 0).
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.

Behaviour:
- Reset (Reset_n=0 at an edge): state IDLE; Busy, Done, ALUResult, Hi, Lo = 0; Zero = 1.
  - Reset wins over any concurrent Start.
  - Reset aborts an in-flight op with no Hi/Lo update.
- Opcodes, single-cycle class:
  - 0000 AND, 0001 OR, 0011 XOR, 1100 NOR
  - 0010 ADD, 0110 SUB: wrap modulo 2^WIDTH, no overflow flag
  - 0111 SLT: signed compare, result 1/0
  - 1111 SLTU: unsigned compare, result 1/0
  - 0100 SLL: B << A[SHAMT_W-1:0]
  - 0101 SRL: B >> A[SHAMT_W-1:0]
  - 1101 MTHI: Hi <= A, ALUResult <= A
  - 1110 MTLO: Lo <= A, ALUResult <= A
  - Undefined code: ALUResult <= 0, completes as single-cycle.
- Opcodes, iterative class:
  - 1000 MULT (signed), 1001 MULTU: {Hi,Lo} <= A*B, 2*WIDTH-bit product.
  - 1010 DIV (signed), 1011 DIVU: Lo <= quotient, Hi <= remainder.
  - Signed division truncates toward zero; remainder takes the sign of the dividend.
- Single-cycle timing:
  - Accepted at edge k; ALUResult/Zero/Hi/Lo update at edge k.
  - Done=1 for the cycle following edge k.
  - Busy stays 0; back-to-back Starts are accepted every cycle.
- Iterative FSM: IDLE -> RUN -> FIX -> IDLE.
  - IDLE: on accept of an iterative op, latch operands, take magnitudes if signed, record result signs, counter <= 0, Busy <= 1, go RUN.
  - RUN: one shift-add (mul) or restoring-subtract (div) step per cycle for exactly WIDTH cycles; counter increments; leave RUN when counter == WIDTH-1.
  - FIX: apply sign correction, write Hi/Lo/ALUResult/Zero, Done <= 1, Busy <= 0, go IDLE.
  - Net latency: Done visible WIDTH+2 edges after the accept edge (34 for WIDTH=32).
- Start handling around iterative ops:
  - Start while Busy=1 is ignored; no queueing.
  - Start in the Done cycle is accepted (Busy already 0).
- Division edge cases:
  - Divide by zero: Lo = all ones, Hi = A (dividend, unmodified). Full WIDTH+2 latency, no exception.
  - Signed most-negative / -1: Lo = most-negative value, Hi = 0.
- Register hold rules:
  - Hi/Lo change only on MULT/DIV family, MTHI or MTLO.
  - ALUResult/Zero hold between completions.
  - Operand changes while Busy have no effect.

Decomposition:
- Package alu_pkg:
  - localparam opcode constants: ALU_AND ... ALU_DIVU.
  - State enum: ST_IDLE, ST_RUN, ST_FIX.
  - Helper function is_iterative(op).
- Sub-module muldiv_iter (WIDTH parameter): holds the shift-add/restoring-divide datapath, counter and sign fix-up. The top block keeps the handshake FSM and single-cycle ops.

Test Plan:
- ADD A=5, B=7 -> ALUResult=12, Zero=0, Done high exactly 1 cycle after accept; SUB A=B=0x1234 -> ALUResult=0, Zero=1.
- SLT A=0xFFFFFFFF, B=1 -> 1; SLTU same operands -> 0; SLL A=4, B=1 -> 0x10.
- MULT A=-3, B=7 -> Busy for 33 cycles, Done at edge 34; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB=ALUResult; MULTU 0xFFFFFFFF*2 -> Hi=1, Lo=0xFFFFFFFE.
- DIVU 100/7 -> Lo=14, Hi=2; DIV -7/2 -> Lo=-3, Hi=-1; DIV 0x80000000/-1 -> Lo=0x80000000, Hi=0; DIVU 9/0 -> Lo=0xFFFFFFFF, Hi=9.
- Start with ADD asserted mid-MULT -> ignored, MULT result unchanged; Start in the Done cycle -> accepted, completes next cycle.
- Reset_n=0 at RUN cycle 10 -> next cycle Busy=0, Done=0, Hi=Lo=ALUResult=0, Zero=1; no Done pulse follows.
